// File: rtl/core_pcg_if.sv
// Fetch-PC handshake between the PC generator and the instruction fetch unit.
interface core_pcg_if;
  logic        pcg_tx_valid;
  logic        pcg_tx_ready;
  logic [31:0] pcg_tx_pc;

  modport master (output pcg_tx_valid, output pcg_tx_pc, input pcg_tx_ready);
  modport slave  (input pcg_tx_valid, input pcg_tx_pc, output pcg_tx_ready);
endinterface

// File: rtl/core_pcg.sv
// PC generator: issues sequential fetch PCs, redirects on taken branches and
// emits the one-cycle branch-result pulses consumed by the IFU.
module core_pcg #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          REDIR_BUBBLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pcg_start,
  input  logic        pcg_halt,
  core_pcg_if.master  tx,
  input  logic        bru_valid,
  input  logic        bru_taken,
  input  logic [31:0] bru_target,
  output logic        pcg_bc_valid,
  output logic        pcg_bc_en,
  output logic [15:0] pcg_redir_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  bubble_q, bubble_d;
  logic        bc_valid_q, bc_valid_d;
  logic        bc_en_q, bc_en_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;

  logic tx_valid;
  logic xfer;
  logic taken;
  logic bubble_last;
  logic unused_target_lsbs;

  assign tx_valid           = (state_q == S_RUN);
  assign xfer               = tx_valid && tx.pcg_tx_ready;
  assign taken              = bru_valid && bru_taken;
  assign bubble_last        = (bubble_q == 4'(REDIR_BUBBLE - 1));
  assign unused_target_lsbs = ^bru_target[1:0];

  assign tx.pcg_tx_valid = tx_valid;
  assign tx.pcg_tx_pc    = pc_q;
  assign pcg_bc_valid    = bc_valid_q;
  assign pcg_bc_en       = bc_en_q;
  assign pcg_redir_cnt   = redir_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bubble_d    = bubble_q;
    bc_valid_d  = bru_valid;
    bc_en_d     = taken;
    redir_cnt_d = redir_cnt_q;

    if (xfer) begin
      pc_d = pc_q + 32'(PC_STEP);
    end

    // A taken redirect overrides the increment; the IFU flushes the issued PC.
    if (taken) begin
      pc_d     = {bru_target[31:2], 2'b00};
      bubble_d = 4'd0;
      if (redir_cnt_q != 16'hFFFF) begin
        redir_cnt_d = redir_cnt_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (pcg_start && !pcg_halt) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (taken) begin
          state_d = S_REDIR;
        end else if (pcg_halt && !(tx_valid && !tx.pcg_tx_ready)) begin
          state_d = S_HALT;
        end
      end
      S_REDIR: begin
        if (!taken) begin
          if (bubble_last) begin
            bubble_d = 4'd0;
            state_d  = pcg_halt ? S_HALT : S_RUN;
          end else begin
            bubble_d = bubble_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      bubble_q    <= 4'd0;
      bc_valid_q  <= 1'b0;
      bc_en_q     <= 1'b0;
      redir_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      bubble_q    <= bubble_d;
      bc_valid_q  <= bc_valid_d;
      bc_en_q     <= bc_en_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_pcg.sv
// Directed bench for core_pcg: stream, stall, redirect, halt, wrap and reset.
module tb_core_pcg;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pcg_start, pcg_halt;
  logic        bru_valid, bru_taken;
  logic [31:0] bru_target;
  logic        pcg_bc_valid, pcg_bc_en;
  logic [15:0] pcg_redir_cnt;

  int n_vec = 0;
  int n_err = 0;

  core_pcg_if u_if ();

  core_pcg u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .pcg_start     (pcg_start),
    .pcg_halt      (pcg_halt),
    .tx            (u_if.master),
    .bru_valid     (bru_valid),
    .bru_taken     (bru_taken),
    .bru_target    (bru_target),
    .pcg_bc_valid  (pcg_bc_valid),
    .pcg_bc_en     (pcg_bc_en),
    .pcg_redir_cnt (pcg_redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt} !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      $display("FAIL reset_values: valid=%0b pc=%h bcv=%0b bce=%0b cnt=%0d, want 0/0/0/0/0",
               u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt);
      n_err++;
    end
    n_vec++;
    u_if.pcg_tx_ready = 1'b1;
    step();
    if (u_if.pcg_tx_valid !== 1'b0 || u_if.pcg_tx_pc !== 32'h0) begin
      $display("FAIL idle_hold: valid=%0b pc=%h, want 0/00000000", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_stream();
    pcg_start = 1'b1;
    step();
    pcg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en} !== {1'b1, 32'(i * 4), 1'b0, 1'b0}) begin
        $display("FAIL stream_%0d: valid=%0b pc=%h bcv=%0b bce=%0b, want 1/%h/0/0",
                 i, u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, 32'(i * 4));
        n_err++;
      end
      n_vec++;
      if (i < 2) step();
    end
  endtask

  task automatic test_stall();
    u_if.pcg_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'h8) begin
        $display("FAIL stall_%0d: valid=%0b pc=%h, want 1/00000008", i, u_if.pcg_tx_valid, u_if.pcg_tx_pc);
        n_err++;
      end
      n_vec++;
    end
    u_if.pcg_tx_ready = 1'b1;
    step();
    if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'hC) begin
      $display("FAIL stall_release: valid=%0b pc=%h, want 1/0000000c", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    step();
  endtask

  // Taken redirect from RUN; leaves the DUT showing the target after the bubble.
  task automatic redirect(input logic [31:0] target, input logic [31:0] exp_pc,
                          input logic [15:0] exp_cnt, input string name);
    bru_valid  = 1'b1;
    bru_taken  = 1'b1;
    bru_target = target;
    step();
    bru_valid = 1'b0;
    bru_taken = 1'b0;
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt} !== {1'b0, exp_pc, 1'b1, 1'b1, exp_cnt}) begin
      $display("FAIL %s_pulse: valid=%0b pc=%h bcv=%0b bce=%0b cnt=%0d, want 0/%h/1/1/%0d",
               name, u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt, exp_pc, exp_cnt);
      n_err++;
    end
    n_vec++;
    step();
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en} !== {1'b1, exp_pc, 1'b0, 1'b0}) begin
      $display("FAIL %s_resume: valid=%0b pc=%h bcv=%0b bce=%0b, want 1/%h/0/0",
               name, u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, exp_pc);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_redirect();
    if (u_if.pcg_tx_pc !== 32'h10) begin
      $display("FAIL pre_redirect_pc: pc=%h, want 00000010", u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    redirect(32'h103, 32'h100, 16'd1, "redir");
  endtask

  task automatic test_not_taken();
    redirect(32'h20, 32'h20, 16'd2, "to20");
    bru_valid = 1'b1;
    bru_taken = 1'b0;
    bru_target = 32'h500;
    step();
    bru_valid = 1'b0;
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt} !== {1'b1, 32'h24, 1'b1, 1'b0, 16'd2}) begin
      $display("FAIL not_taken_pulse: valid=%0b pc=%h bcv=%0b bce=%0b cnt=%0d, want 1/00000024/1/0/2",
               u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt);
      n_err++;
    end
    n_vec++;
    step();
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid} !== {1'b1, 32'h28, 1'b0}) begin
      $display("FAIL not_taken_next: valid=%0b pc=%h bcv=%0b, want 1/00000028/0",
               u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_halt();
    redirect(32'h30, 32'h30, 16'd3, "to30");
    u_if.pcg_tx_ready = 1'b0;
    pcg_halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'h30) begin
        $display("FAIL halt_pending_%0d: valid=%0b pc=%h, want 1/00000030", i, u_if.pcg_tx_valid, u_if.pcg_tx_pc);
        n_err++;
      end
      n_vec++;
    end
    u_if.pcg_tx_ready = 1'b1;
    step();
    if (u_if.pcg_tx_valid !== 1'b0 || u_if.pcg_tx_pc !== 32'h34) begin
      $display("FAIL halt_enter: valid=%0b pc=%h, want 0/00000034", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    pcg_start = 1'b1;
    step();
    if (u_if.pcg_tx_valid !== 1'b0 || u_if.pcg_tx_pc !== 32'h34) begin
      $display("FAIL halt_beats_start: valid=%0b pc=%h, want 0/00000034", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    pcg_halt = 1'b0;
    step();
    pcg_start = 1'b0;
    if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'h34) begin
      $display("FAIL halt_resume: valid=%0b pc=%h, want 1/00000034", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_wrap_back_to_back();
    redirect(32'hFFFF_FFFF, 32'hFFFF_FFFC, 16'd4, "tomax");
    step();
    if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'h0) begin
      $display("FAIL wrap: valid=%0b pc=%h, want 1/00000000", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    bru_valid = 1'b1;
    bru_taken = 1'b1;
    bru_target = 32'h40;
    step();
    bru_taken = 1'b0;
    if ({pcg_bc_valid, pcg_bc_en, pcg_redir_cnt, u_if.pcg_tx_pc} !== {1'b1, 1'b1, 16'd5, 32'h40}) begin
      $display("FAIL b2b_first: bcv=%0b bce=%0b cnt=%0d pc=%h, want 1/1/5/00000040",
               pcg_bc_valid, pcg_bc_en, pcg_redir_cnt, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    step();
    bru_valid = 1'b0;
    if ({pcg_bc_valid, pcg_bc_en, u_if.pcg_tx_valid, u_if.pcg_tx_pc} !== {1'b1, 1'b0, 1'b1, 32'h40}) begin
      $display("FAIL b2b_second: bcv=%0b bce=%0b valid=%0b pc=%h, want 1/0/1/00000040",
               pcg_bc_valid, pcg_bc_en, u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
    step();
    if (pcg_bc_valid !== 1'b0 || u_if.pcg_tx_pc !== 32'h44) begin
      $display("FAIL b2b_done: bcv=%0b pc=%h, want 0/00000044", pcg_bc_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid_redir();
    bru_valid = 1'b1;
    bru_taken = 1'b1;
    bru_target = 32'h200;
    step();
    rstn = 1'b0;
    #1;
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt} !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      $display("FAIL async_reset: valid=%0b pc=%h bcv=%0b bce=%0b cnt=%0d, want 0/0/0/0/0",
               u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_bc_valid, pcg_bc_en, pcg_redir_cnt);
      n_err++;
    end
    n_vec++;
    bru_valid = 1'b0;
    bru_taken = 1'b0;
    step();
    rstn = 1'b1;
    step();
    if (u_if.pcg_tx_valid !== 1'b0) begin
      $display("FAIL reset_dropped_redirect: valid=%0b, want 0", u_if.pcg_tx_valid);
      n_err++;
    end
    n_vec++;
    pcg_start = 1'b1;
    step();
    pcg_start = 1'b0;
    if (u_if.pcg_tx_valid !== 1'b1 || u_if.pcg_tx_pc !== 32'h0) begin
      $display("FAIL restart_pc: valid=%0b pc=%h, want 1/00000000", u_if.pcg_tx_valid, u_if.pcg_tx_pc);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_halt_redirect();
    pcg_halt = 1'b1;
    step();
    pcg_halt = 1'b0;
    bru_valid = 1'b1;
    bru_taken = 1'b1;
    bru_target = 32'h81;
    step();
    bru_valid = 1'b0;
    bru_taken = 1'b0;
    step();
    if ({u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_redir_cnt} !== {1'b0, 32'h80, 16'd1}) begin
      $display("FAIL halt_redirect: valid=%0b pc=%h cnt=%0d, want 0/00000080/1",
               u_if.pcg_tx_valid, u_if.pcg_tx_pc, pcg_redir_cnt);
      n_err++;
    end
    n_vec++;
  endtask

  initial begin
    rstn = 1'b0;
    pcg_start = 1'b0;
    pcg_halt = 1'b0;
    bru_valid = 1'b0;
    bru_taken = 1'b0;
    bru_target = 32'h0;
    u_if.pcg_tx_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_not_taken();
    test_halt();
    test_wrap_back_to_back();
    test_reset_mid_redir();
    test_halt_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_pcg.md
Name: core_pcg

Overview:
- PC generator stage directly upstream of the instruction fetch unit (IFU).
- Issues a stream of fetch PCs to the IFU over a valid/ready handshake.
- Takes branch resolutions from the execute-stage branch unit and redirects the PC stream on a taken branch.
- Produces the one-cycle branch-result pulses the IFU uses to leave its branch-pending state and to flush discarded instructions.

Parameters:
- RESET_PC, 32'h0000_0000: first PC issued after reset.
- PC_STEP, 4: increment applied after each accepted PC.
- REDIR_BUBBLE, 1: cycles with pcg_tx_valid low after a taken redirect (range 1..15).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous assert, active-low
- pcg_start  in  1  leave IDLE/HALT and begin issuing
- pcg_halt  in  1  stop issuing new PCs
- pcg_tx_valid  out  1  PC offer valid (to IFU rx_valid)
- pcg_tx_ready  in  1  IFU ready (IFU rx_ready)
- pcg_tx_pc  out  32  offered PC (to IFU rx_pc)
- bru_valid  in  1  branch resolution valid, single-cycle pulse
- bru_taken  in  1  resolved branch is taken
- bru_target  in  32  redirect target
- pcg_bc_valid  out  1  registered pulse: branch result available (IFU pc_valid)
- pcg_bc_en  out  1  registered pulse: branch taken, flush (IFU bc_en)
- pcg_redir_cnt  out  16  count of taken redirects, saturating

Behaviour:
- Reset values:
  - state = IDLE.
  - pc_q = RESET_PC.
  - pcg_tx_valid = 0; pcg_bc_valid = 0; pcg_bc_en = 0; pcg_redir_cnt = 0.
  - Bubble counter = 0.
  - A reset asserted mid-operation returns everything to these values immediately and drops any pending redirect.
- pcg_tx_pc = pc_q at all times.
- pcg_tx_valid is combinational: 1 only in RUN.
- Handshake:
  - A transfer occurs when pcg_tx_valid && pcg_tx_ready.
  - On a transfer, pc_q <= pc_q + PC_STEP (32-bit wrap: 0xFFFF_FFFC + 4 = 0).
  - While valid && !ready, pc_q holds. A redirect is the only event allowed to change pc_q under a pending offer.
- States:
  - IDLE: valid 0. pcg_start -> RUN next cycle.
  - RUN: valid 1. Exit conditions, highest priority first:
    - bru_valid && bru_taken -> REDIR.
    - pcg_halt && !(valid && !ready) -> HALT. Halt is ignored while an offer is pending unaccepted. A transfer in the same cycle as halt still completes and increments pc_q.
  - REDIR: valid 0. Bubble counter counts 0..REDIR_BUBBLE-1, then RUN. If pcg_halt is high at exit, go to HALT instead.
  - HALT: valid 0. pcg_start -> RUN; pc_q is preserved.
- Branch resolution, when bru_valid is sampled:
  - In the next cycle pcg_bc_valid = 1 for exactly one cycle.
  - If taken, pcg_bc_en = 1 in that same cycle.
  - Taken: pc_q <= {bru_target[31:2], 2'b00}. This overrides any same-cycle transfer increment; that transfer still counts as issued, and the IFU flushes it.
  - Taken: pcg_redir_cnt += 1, saturating at 0xFFFF.
  - Taken: bubble counter cleared.
  - Not taken: pc_q and state are unaffected.
- Redirect during REDIR: new target is loaded, bubble counter restarts, a new pulse pair is issued, and the counter increments.
- Redirect in IDLE/HALT: pc_q, pulses and counter update as above; state is unchanged.
- Back-to-back bru_valid on consecutive cycles yields back-to-back pulses (one per resolution, one cycle delayed).
- pcg_start and pcg_halt both high in HALT/IDLE: halt wins, state stays.

Test Plan:
- Reset, pcg_start, ready=1 for 4 cycles -> pcg_tx_pc 0,4,8,C issued one per cycle; pcg_bc_valid/en stay 0.
- Ready low 3 cycles while valid at PC 0x8 -> pcg_tx_pc holds 0x8, valid stays 1; ready high -> next PC 0xC.
- In RUN at PC 0x10 with ready=1, bru_valid=1, bru_taken=1, bru_target=0x103 -> next cycle bc_valid=bc_en=1 for 1 cycle, valid=0 for 1 cycle, then PC 0x100 offered; redir_cnt=1.
- bru_valid=1, bru_taken=0 at PC 0x20 -> bc_valid=1, bc_en=0 next cycle; stream continues 0x24,0x28 without bubble.
- pcg_halt at PC 0x30 with ready=0 -> valid held until accepted, then HALT, pc_q=0x34; pcg_start -> resumes at 0x34.
- pc_q=0xFFFF_FFFC accepted -> next PC 0x0. Then rstn low mid-REDIR -> all outputs at reset values, PC RESET_PC after restart.
